hazard_controller: RTL

Central stall/flush sequencer for the 5-stage RV32I pipeline; sits beside the decode stage and drives the PC, IF/ID, ID/EX, EX/MEM and MEM/WB register enables and flushes. Resolves three hazard sources in strict priority: data-memory wait (freeze), taken branch in EX (flush), and load-use in ID (stall). Owns a memory-wait FSM with timeout detection, plus saturating stall and flush performance counters.

---
 rtl/hazard_controller_pkg.sv | 23 ++
 rtl/hazard_controller_sat_counter.sv | 25 ++
 rtl/hazard_controller.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/hazard_controller_pkg.sv
// Shared definitions for the pipeline hazard controller: FSM state encodings,
// default register-index width, and the packed bundle of pipeline controls.
package hazard_controller_pkg;

  localparam int unsigned REG_ADDR_W_DEF = 5;

  // Memory-wait FSM encodings
  localparam logic [1:0] ST_RUN      = 2'd0;
  localparam logic [1:0] ST_MEM_WAIT = 2'd1;
  localparam logic [1:0] ST_FAULT    = 2'd2;

  // Per-cycle pipeline register controls driven by the hazard controller
  typedef struct packed {
    logic pc_write_en;
    logic ifid_write_en;
    logic ifid_flush;
    logic idex_write_en;
    logic idex_flush;
    logic exmem_write_en;
    logic memwb_bubble;
  } hz_ctrl_t;

endpackage

// File: rtl/hazard_controller_sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
// Ports: clk, rst_n (async clear), i_inc (count enable), o_cnt (value).
module sat_counter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_inc,
  output logic [CNT_W-1:0] o_cnt
);

  logic [CNT_W-1:0] r_cnt;

  // Hold at all-ones instead of wrapping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_inc && (r_cnt != {CNT_W{1'b1}})) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/hazard_controller.sv
// Stall/flush sequencer for the 5-stage pipeline. Priority: memory freeze >
// taken branch flush > load-use stall. Owns the memory-wait FSM with timeout
// fault and saturating stall/flush performance counters.
// Ports:
//   clk, rst_n                      clock, async active-low reset
//   i_id_rs1/rs2, i_id_uses_rs1/rs2 ID source operands and their use flags
//   i_ex_mem_read, i_ex_rd          load in EX and its destination
//   i_ex_branch_taken               branch in EX resolved taken
//   i_mem_req, i_mem_ready          MEM-stage access request / completion
//   o_*_write_en, o_*_flush,
//   o_memwb_bubble                  pipeline register controls (combinational)
//   o_timeout_err                   sticky memory-timeout fault
//   o_stall_cnt, o_flush_cnt        saturating performance counters
module hazard_controller
  import hazard_controller_pkg::*;
#(
  parameter int unsigned REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int unsigned MAX_WAIT   = 15,
  parameter int unsigned WAIT_W     = 4,
  parameter int unsigned CNT_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [REG_ADDR_W-1:0] i_id_rs1,
  input  logic [REG_ADDR_W-1:0] i_id_rs2,
  input  logic                  i_id_uses_rs1,
  input  logic                  i_id_uses_rs2,
  input  logic                  i_ex_mem_read,
  input  logic [REG_ADDR_W-1:0] i_ex_rd,
  input  logic                  i_ex_branch_taken,
  input  logic                  i_mem_req,
  input  logic                  i_mem_ready,
  output logic                  o_pc_write_en,
  output logic                  o_ifid_write_en,
  output logic                  o_ifid_flush,
  output logic                  o_idex_write_en,
  output logic                  o_idex_flush,
  output logic                  o_exmem_write_en,
  output logic                  o_memwb_bubble,
  output logic                  o_timeout_err,
  output logic [CNT_W-1:0]      o_stall_cnt,
  output logic [CNT_W-1:0]      o_flush_cnt
);

  logic [1:0]        r_state;
  logic [1:0]        w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_nxt;
  logic              r_timeout_err;
  logic              w_err_nxt;

  logic              w_mem_stall;
  logic              w_freeze;
  logic              w_load_use;
  logic              w_branch;
  logic              w_lu_stall;
  hz_ctrl_t          w_ctrl;

  // Hazard detection; x0 is never a real dependency
  always_comb begin
    w_mem_stall = i_mem_req && !i_mem_ready;
    w_freeze    = (r_state == ST_MEM_WAIT) || (r_state == ST_FAULT) ||
                  ((r_state == ST_RUN) && w_mem_stall);
    w_load_use  = i_ex_mem_read && (i_ex_rd != '0) &&
                  ((i_id_uses_rs1 && (i_id_rs1 == i_ex_rd)) ||
                   (i_id_uses_rs2 && (i_id_rs2 == i_ex_rd)));
    w_branch    = !w_freeze && i_ex_branch_taken;
    w_lu_stall  = !w_freeze && !i_ex_branch_taken && w_load_use;
  end

  // Pipeline controls: freeze holds everything and feeds a bubble into WB
  always_comb begin
    w_ctrl = '{pc_write_en: 1'b1, ifid_write_en: 1'b1, ifid_flush: 1'b0,
               idex_write_en: 1'b1, idex_flush: 1'b0, exmem_write_en: 1'b1,
               memwb_bubble: 1'b0};
    if (w_freeze) begin
      w_ctrl = '{pc_write_en: 1'b0, ifid_write_en: 1'b0, ifid_flush: 1'b0,
                 idex_write_en: 1'b0, idex_flush: 1'b0, exmem_write_en: 1'b0,
                 memwb_bubble: 1'b1};
    end else if (w_branch) begin
      w_ctrl.ifid_flush = 1'b1;
      w_ctrl.idex_flush = 1'b1;
    end else if (w_lu_stall) begin
      w_ctrl.pc_write_en   = 1'b0;
      w_ctrl.ifid_write_en = 1'b0;
      w_ctrl.idex_flush    = 1'b1;
    end
  end

  // Memory-wait FSM next state; the ready cycle still freezes, so release
  // costs exactly one extra cycle
  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = r_wait_cnt;
    w_err_nxt   = r_timeout_err;
    case (r_state)
      ST_RUN: begin
        if (w_mem_stall) begin
          w_state_nxt = ST_MEM_WAIT;
          w_wait_nxt  = WAIT_W'(1);
        end
      end
      ST_MEM_WAIT: begin
        if (i_mem_ready) begin
          w_state_nxt = ST_RUN;
          w_wait_nxt  = '0;
        end else if (r_wait_cnt == WAIT_W'(MAX_WAIT)) begin
          w_state_nxt = ST_FAULT;
          w_err_nxt   = 1'b1;
        end else begin
          w_wait_nxt  = r_wait_cnt + WAIT_W'(1);
        end
      end
      ST_FAULT: begin
        w_state_nxt = ST_FAULT;
      end
      default: begin
        w_state_nxt = ST_RUN;
        w_wait_nxt  = '0;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= ST_RUN;
      r_wait_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_wait_cnt    <= w_wait_nxt;
      r_timeout_err <= w_err_nxt;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_freeze || w_lu_stall),
    .o_cnt (o_stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_inc (w_branch),
    .o_cnt (o_flush_cnt)
  );

  assign o_pc_write_en    = w_ctrl.pc_write_en;
  assign o_ifid_write_en  = w_ctrl.ifid_write_en;
  assign o_ifid_flush     = w_ctrl.ifid_flush;
  assign o_idex_write_en  = w_ctrl.idex_write_en;
  assign o_idex_flush     = w_ctrl.idex_flush;
  assign o_exmem_write_en = w_ctrl.exmem_write_en;
  assign o_memwb_bubble   = w_ctrl.memwb_bubble;
  assign o_timeout_err    = r_timeout_err;

endmodule
